// File: rtl/regfile_mp_sb.sv
// Multi-port GPR file with per-register busy scoreboard for the ID stage.
// Combinational reads with optional write bypass; registered writes and busy bits.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [CNT_W-1:0]  busy_cnt_q;
    logic [CNT_W-1:0]  busy_cnt_d;

    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wv;

    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic [DEPTH-1:0]  rise_vec;
    logic [DEPTH-1:0]  fall_vec;
    logic [CNT_W-1:0]  fall_cnt;

    logic [ADDR_W-1:0] ra  [NUM_RD];
    logic [NUM_RD-1:0] hit;
    logic [DATA_W-1:0] hv  [NUM_RD];

    // Unpack write ports; writes to a hardwired r0 are dropped here.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k] = waddr[k*ADDR_W +: ADDR_W];
            wd[k] = wdata[k*DATA_W +: DATA_W];
            wv[k] = we[k] && !(HAS_ZERO && (wa[k] == '0));
        end
    end

    // Next register contents; later ports override earlier ones on collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (wv[k]) begin
                regs_d[wa[k]] = wd[k];
            end
        end
    end

    // Scoreboard next state: a reservation beats a same-cycle writeback.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (rsv_en && !(HAS_ZERO && (rsv_addr == '0))) begin
            set_vec[rsv_addr] = 1'b1;
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (we[k]) begin
                clr_vec[wa[k]] = 1'b1;
            end
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy counter tracks popcount incrementally from bit transitions.
    always_comb begin
        rise_vec = set_vec & ~busy_q;
        fall_vec = clr_vec & busy_q & ~set_vec;
        fall_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fall_cnt = fall_cnt + CNT_W'(fall_vec[i]);
        end
        busy_cnt_d = busy_cnt_q + CNT_W'(|rise_vec) - fall_cnt;
    end

    // Per read port: find the highest-indexed same-cycle write hit.
    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra[p] = raddr[p*ADDR_W +: ADDR_W];
            hv[p] = '0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (we[k] && (wa[k] == ra[p])) begin
                    hit[p] = 1'b1;
                    hv[p]  = wd[k];
                end
            end
        end
    end

    // Read mux and hazard flag per port.
    always_comb begin
        rdata   = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!rst && re[p]) begin
                if (HAS_ZERO && (ra[p] == '0)) begin
                    rdata[p*DATA_W +: DATA_W] = '0;
                end else if (HAS_BYP && hit[p]) begin
                    rdata[p*DATA_W +: DATA_W] = hv[p];
                end else begin
                    rdata[p*DATA_W +: DATA_W] = regs_q[ra[p]];
                end
                rd_busy[p] = busy_q[ra[p]] & ~(HAS_BYP & hit[p]);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: bypass/2-write instance and
// a no-bypass 1-write instance sharing clock and reset.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]  a_we;
    logic [9:0]  a_waddr;
    logic [63:0] a_wdata;
    logic [1:0]  a_re;
    logic [9:0]  a_raddr;
    logic [63:0] a_rdata;
    logic [1:0]  a_rd_busy;
    logic        a_rsv_en;
    logic [4:0]  a_rsv_addr;
    logic [5:0]  a_busy_cnt;

    logic [0:0]  b_we;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [1:0]  b_re;
    logic [9:0]  b_raddr;
    logic [63:0] b_rdata;
    logic [1:0]  b_rd_busy;
    logic        b_rsv_en;
    logic [4:0]  b_rsv_addr;
    logic [5:0]  b_busy_cnt;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
        .ZERO_REG(1), .BYPASS(1)
    ) u_a (
        .clk(clk), .rst(rst),
        .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .re(a_re), .raddr(a_raddr), .rdata(a_rdata),
        .rd_busy(a_rd_busy), .rsv_en(a_rsv_en),
        .rsv_addr(a_rsv_addr), .busy_cnt(a_busy_cnt)
    );

    regfile_mp_sb #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1),
        .ZERO_REG(1), .BYPASS(0)
    ) u_b (
        .clk(clk), .rst(rst),
        .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .re(b_re), .raddr(b_raddr), .rdata(b_rdata),
        .rd_busy(b_rd_busy), .rsv_en(b_rsv_en),
        .rsv_addr(b_rsv_addr), .busy_cnt(b_busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_we = '0; a_waddr = '0; a_wdata = '0;
        a_re = '0; a_raddr = '0; a_rsv_en = 1'b0; a_rsv_addr = '0;
        b_we = '0; b_waddr = '0; b_wdata = '0;
        b_re = '0; b_raddr = '0; b_rsv_en = 1'b0; b_rsv_addr = '0;
        tick();
        tick();

        // reset clears data and reservations
        rst = 1'b0;
        a_we = 2'b01; a_waddr[4:0] = 5'd5; a_wdata[31:0] = 32'hDEADBEEF;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd5;
        a_re = 2'b01; a_raddr[4:0] = 5'd5;
        #4 chk("byp_r5", a_rdata[31:0], 32'hDEADBEEF);
        tick();
        a_we = '0; a_rsv_en = 1'b0;
        #4 chk("r5_val", a_rdata[31:0], 32'hDEADBEEF);
        chk("r5_busy", a_rd_busy, 2'b01);
        chk("r5_cnt", a_busy_cnt, 6'd1);
        tick();
        rst = 1'b1;
        #4 chk("rst_rdata", a_rdata, 64'h0);
        chk("rst_rdbusy", a_rd_busy, 2'b00);
        tick();
        rst = 1'b0;
        #4 chk("post_rst_r5", a_rdata[31:0], 32'h0);
        chk("post_rst_cnt", a_busy_cnt, 6'd0);
        chk("post_rst_busy", a_rd_busy, 2'b00);

        // write then read with bypass
        a_we = 2'b01; a_waddr[4:0] = 5'd3; a_wdata[31:0] = 32'h12345678;
        a_raddr[4:0] = 5'd3;
        #4 chk("wr3_byp", a_rdata[31:0], 32'h12345678);
        tick();
        a_we = '0; a_re = 2'b11; a_raddr[9:5] = 5'd3;
        #4 chk("wr3_p0", a_rdata[31:0], 32'h12345678);
        chk("wr3_p1", a_rdata[63:32], 32'h12345678);

        // zero register
        a_we = 2'b01; a_waddr[4:0] = 5'd0; a_wdata[31:0] = 32'hFFFFFFFF;
        a_re = 2'b01; a_raddr[4:0] = 5'd0;
        #4 chk("r0_wr_cyc", a_rdata[31:0], 32'h0);
        tick();
        a_we = '0; a_rsv_en = 1'b1; a_rsv_addr = 5'd0;
        #4 chk("r0_rd", a_rdata[31:0], 32'h0);
        tick();
        a_rsv_en = 1'b0;
        #4 chk("r0_cnt", a_busy_cnt, 6'd0);
        chk("r0_rdbusy", a_rd_busy, 2'b00);
        chk("r0_rd2", a_rdata[31:0], 32'h0);

        // scoreboard on r7
        a_re = 2'b11; a_raddr = {5'd7, 5'd7};
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7;
        #4 chk("r7_c0_busy", a_rd_busy, 2'b00);
        tick();
        a_rsv_en = 1'b0;
        #4 chk("r7_c1_busy", a_rd_busy, 2'b11);
        chk("r7_c1_cnt", a_busy_cnt, 6'd1);
        tick();
        tick();
        #4 chk("r7_c3_busy", a_rd_busy, 2'b11);
        tick();
        a_we = 2'b01; a_waddr[4:0] = 5'd7; a_wdata[31:0] = 32'hA5;
        #4 chk("r7_c4_busy", a_rd_busy, 2'b00);
        chk("r7_c4_data", a_rdata[31:0], 32'hA5);
        chk("r7_c4_cnt", a_busy_cnt, 6'd1);
        tick();
        a_we = '0;
        #4 chk("r7_c5_cnt", a_busy_cnt, 6'd0);
        chk("r7_c5_busy", a_rd_busy, 2'b00);
        chk("r7_c5_data", a_rdata[31:0], 32'hA5);
        a_re = 2'b10;
        #4 chk("re0_off_data", a_rdata[31:0], 32'h0);
        chk("re0_off_busy", a_rd_busy, 2'b00);

        // two-port collision plus reservation on r9
        a_we = 2'b11; a_waddr = {5'd9, 5'd9};
        a_wdata = {32'h2, 32'h1};
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9;
        a_re = 2'b01; a_raddr[4:0] = 5'd9;
        #4 chk("col_byp", a_rdata[31:0], 32'h2);
        tick();
        a_we = '0; a_rsv_en = 1'b0;
        #4 chk("col_data", a_rdata[31:0], 32'h2);
        chk("col_cnt", a_busy_cnt, 6'd1);
        chk("col_busy", a_rd_busy, 2'b01);

        // counting: re-reserve, multi-clear, non-busy write
        a_rsv_en = 1'b1; a_rsv_addr = 5'd10;
        tick();
        a_rsv_addr = 5'd11;
        tick();
        a_rsv_addr = 5'd10;
        tick();
        a_rsv_en = 1'b0;
        #4 chk("cnt3", a_busy_cnt, 6'd3);
        a_we = 2'b11; a_waddr = {5'd11, 5'd10}; a_wdata = 64'h0;
        tick();
        a_we = '0;
        #4 chk("cnt_dual_clr", a_busy_cnt, 6'd1);
        a_we = 2'b01; a_waddr[4:0] = 5'd12; a_wdata[31:0] = 32'h77;
        tick();
        a_we = '0;
        #4 chk("cnt_nonbusy", a_busy_cnt, 6'd1);
        a_we = 2'b10; a_waddr[9:5] = 5'd9; a_wdata[63:32] = 32'h99;
        a_raddr[4:0] = 5'd9;
        #4 chk("r9_byp_busy", a_rd_busy, 2'b00);
        tick();
        a_we = '0;
        #4 chk("r9_cnt0", a_busy_cnt, 6'd0);

        // no-bypass instance
        b_we = 1'b1; b_waddr = 5'd4; b_wdata = 32'h11;
        tick();
        b_we = 1'b0; b_rsv_en = 1'b1; b_rsv_addr = 5'd4;
        tick();
        b_rsv_en = 1'b0;
        b_we = 1'b1; b_wdata = 32'h55;
        b_re = 2'b01; b_raddr[4:0] = 5'd4;
        #4 chk("nb_old", b_rdata[31:0], 32'h11);
        chk("nb_busy", b_rd_busy, 2'b01);
        chk("nb_cnt1", b_busy_cnt, 6'd1);
        tick();
        b_we = 1'b0;
        #4 chk("nb_new", b_rdata[31:0], 32'h55);
        chk("nb_busy0", b_rd_busy, 2'b00);
        chk("nb_cnt0", b_busy_cnt, 6'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
